// File: rtl/mul_reg_acc_if.sv
// Bus interface for mul_reg_acc: write port, RD_PORTS read ports and status flags.
// The DUT attaches through the slave modport; whoever drives it uses the master modport.
interface mul_reg_acc_if #(
    parameter int W        = 16,
    parameter int AW       = 2,
    parameter int N        = 3,
    parameter int RD_PORTS = 2
);
    logic                   mreg_clr_i;
    logic                   mreg_wr_en_i;
    logic                   mreg_acc_i;
    logic [AW-1:0]          mreg_wr_addrs_i;
    logic signed [W-1:0]    wr_data_i;
    logic [RD_PORTS-1:0]    mreg_rd_en_i;
    logic [RD_PORTS*AW-1:0] mreg_rd_addrs_i;
    logic [RD_PORTS*W-1:0]  rd_data_o;
    logic [RD_PORTS-1:0]    rd_valid_o;
    logic [N-1:0]           written_o;
    logic                   ovf_o;

    modport master (
        output mreg_clr_i, mreg_wr_en_i, mreg_acc_i, mreg_wr_addrs_i, wr_data_i,
               mreg_rd_en_i, mreg_rd_addrs_i,
        input  rd_data_o, rd_valid_o, written_o, ovf_o
    );

    modport slave (
        input  mreg_clr_i, mreg_wr_en_i, mreg_acc_i, mreg_wr_addrs_i, wr_data_i,
               mreg_rd_en_i, mreg_rd_addrs_i,
        output rd_data_o, rd_valid_o, written_o, ovf_o
    );
endinterface

// File: rtl/mul_reg_acc.sv
// Multi-read-port Q(I.F) register file with accumulate-on-write, registered reads and sticky overflow.
// Define MREG_SAT_EN to saturate accumulate overflow instead of wrapping modulo 2^W.
module mul_reg_acc #(
    parameter int I_WIDTH     = 8,
    parameter int F_WIDTH     = 8,
    parameter int N           = 3,
    parameter int ADDRS_WIDTH = $clog2(N),
    parameter int RD_PORTS    = 2
) (
    input  logic clk_i,
    input  logic mreg_rst_i,
    mul_reg_acc_if.slave bus
);
    localparam int W  = I_WIDTH + F_WIDTH;
    localparam int AW = ADDRS_WIDTH;

    logic [W-1:0]        mem_q      [N];
    logic [W-1:0]        mem_d      [N];
    logic [W-1:0]        rd_data_q  [RD_PORTS];
    logic [W-1:0]        rd_data_d  [RD_PORTS];
    logic [RD_PORTS-1:0] rd_valid_q, rd_valid_d;
    logic [N-1:0]        written_q, written_d;
    logic                ovf_q, ovf_d;

    logic                wr_hit;
    logic [W-1:0]        wr_old;
    logic [W:0]          acc_sum;
    logic                acc_ovf;
    logic [W-1:0]        acc_val;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return int'(a) < N;
    endfunction

    // Accumulate datapath: sign-extended W+1-bit sum, overflow when the top two bits disagree.
    always_comb begin
        wr_hit = bus.mreg_wr_en_i && addr_ok(bus.mreg_wr_addrs_i);
        wr_old = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(bus.mreg_wr_addrs_i) == i) begin
                wr_old = mem_q[i];
            end
        end
        acc_sum = {wr_old[W-1], wr_old} + {bus.wr_data_i[W-1], bus.wr_data_i};
        acc_ovf = acc_sum[W] != acc_sum[W-1];
`ifdef MREG_SAT_EN
        if (acc_ovf) begin
            acc_val = acc_sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            acc_val = acc_sum[W-1:0];
        end
`else
        acc_val = acc_sum[W-1:0];
`endif
    end

    // Next-state for entries and flags; clear has priority and drops the same-cycle write.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            mem_d[i] = mem_q[i];
        end
        written_d = written_q;
        ovf_d     = ovf_q;
        if (bus.mreg_clr_i) begin
            for (int i = 0; i < N; i++) begin
                mem_d[i] = '0;
            end
            written_d = '0;
            ovf_d     = 1'b0;
        end else if (wr_hit) begin
            for (int i = 0; i < N; i++) begin
                if (int'(bus.mreg_wr_addrs_i) == i) begin
                    mem_d[i]     = bus.mreg_acc_i ? acc_val : bus.wr_data_i;
                    written_d[i] = 1'b1;
                end
            end
            if (bus.mreg_acc_i && acc_ovf) begin
                ovf_d = 1'b1;
            end
        end
    end

    // Reads look at mem_d so a read colliding with a write returns the post-write value.
    always_comb begin
        for (int k = 0; k < RD_PORTS; k++) begin
            rd_data_d[k]  = rd_data_q[k];
            rd_valid_d[k] = 1'b0;
            if (bus.mreg_clr_i) begin
                rd_data_d[k] = '0;
            end else if (bus.mreg_rd_en_i[k]) begin
                rd_valid_d[k] = 1'b1;
                rd_data_d[k]  = '0;
                for (int i = 0; i < N; i++) begin
                    if (int'(bus.mreg_rd_addrs_i[k*AW +: AW]) == i) begin
                        rd_data_d[k] = mem_d[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge mreg_rst_i) begin
        if (mreg_rst_i) begin
            for (int i = 0; i < N; i++) begin
                mem_q[i] <= '0;
            end
            for (int k = 0; k < RD_PORTS; k++) begin
                rd_data_q[k] <= '0;
            end
            rd_valid_q <= '0;
            written_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                mem_q[i] <= mem_d[i];
            end
            for (int k = 0; k < RD_PORTS; k++) begin
                rd_data_q[k] <= rd_data_d[k];
            end
            rd_valid_q <= rd_valid_d;
            written_q  <= written_d;
            ovf_q      <= ovf_d;
        end
    end

    for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd_out
        assign bus.rd_data_o[k*W +: W] = rd_data_q[k];
    end
    assign bus.rd_valid_o = rd_valid_q;
    assign bus.written_o  = written_q;
    assign bus.ovf_o      = ovf_q;
endmodule
